// File: rtl/lcd_pkg.sv
// Shared LCD geometry, pixel type and colour constants for the ball display path.
package lcd_pkg;
  localparam int LCD_H_RES = 320;
  localparam int LCD_V_RES = 240;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t COLOR_WHITE = 16'hFFFF;
  localparam rgb565_t COLOR_BLUE  = 16'h001F;
endpackage

// File: rtl/raster_counter.sv
// Column/line counter for a raster scan; steps one pixel per advance, wraps at frame end.
// Position updates on the edge after advance; holds otherwise.
module raster_counter
  import lcd_pkg::*;
#(
  parameter int H_RES = LCD_H_RES,
  parameter int V_RES = LCD_V_RES
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       advance,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       atLineEnd,
  output logic       atFrameEnd
);

  logic [8:0] r_x;
  logic [7:0] r_y;

  assign atLineEnd  = (r_x == 9'(H_RES - 1));
  assign atFrameEnd = atLineEnd && (r_y == 8'(V_RES - 1));
  assign x          = r_x;
  assign y          = r_y;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_x <= '0;
      r_y <= '0;
    end else if (advance) begin
      if (atLineEnd) begin
        r_x <= '0;
        r_y <= atFrameEnd ? '0 : r_y + 8'd1;
      end else begin
        r_x <= r_x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/ball_frame_scanner.sv
// Walks the frame, queries the renderer and streams one RGB565 pixel per coordinate (1-cycle latency).
// Output register holds under backpressure; accept and re-issue overlap for 1 pixel/cycle.
module ball_frame_scanner
  import lcd_pkg::*;
#(
  parameter int      H_RES     = LCD_H_RES,
  parameter int      V_RES     = LCD_V_RES,
  parameter int      FRAME_DIV = 1,
  parameter rgb565_t FG_COLOR  = COLOR_WHITE,
  parameter rgb565_t BG_COLOR  = COLOR_BLUE
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       enable,
  output logic [8:0] checkX,
  output logic [7:0] checkY,
  input  logic       isSet,
  output rgb565_t    pixelData,
  output logic       pixelValid,
  input  logic       pixelReady,
  output logic       frameStart,
  output logic       lineEnd,
  output logic       physicsClk
);

  localparam int             FCW     = $clog2(FRAME_DIV + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_DIV - 1);

  logic           w_issue;
  logic [8:0]     w_x;
  logic [7:0]     w_y;
  logic           w_atLineEnd;
  logic           w_atFrameEnd;
  logic           w_frameDone;
  logic           w_divWrap;

  rgb565_t        r_pixelData;
  logic           r_pixelValid;
  logic           r_frameStart;
  logic           r_lineEnd;
  logic           r_physicsClk;
  logic [FCW-1:0] r_frameCnt;

  // A new pixel may enter the output register when it is empty or draining this cycle.
  assign w_issue     = enable && (!r_pixelValid || pixelReady);
  assign w_frameDone = w_issue && w_atFrameEnd;
  assign w_divWrap   = (r_frameCnt == FC_LAST);

  raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster (
    .clk       (clk),
    .rstN      (rstN),
    .advance   (w_issue),
    .x         (w_x),
    .y         (w_y),
    .atLineEnd (w_atLineEnd),
    .atFrameEnd(w_atFrameEnd)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pixelData  <= '0;
      r_pixelValid <= 1'b0;
      r_frameStart <= 1'b0;
      r_lineEnd    <= 1'b0;
    end else if (w_issue) begin
      r_pixelData  <= isSet ? FG_COLOR : BG_COLOR;
      r_pixelValid <= 1'b1;
      r_frameStart <= (w_x == 9'd0) && (w_y == 8'd0);
      r_lineEnd    <= w_atLineEnd;
    end else if (pixelReady) begin
      r_pixelValid <= 1'b0;
    end
  end

  // The pulse lands right after the last pixel issues, so the renderer moves between frames.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_frameCnt   <= '0;
      r_physicsClk <= 1'b0;
    end else begin
      r_physicsClk <= w_frameDone && w_divWrap;
      if (w_frameDone) begin
        r_frameCnt <= w_divWrap ? '0 : r_frameCnt + FCW'(1);
      end
    end
  end

  assign checkX     = w_x;
  assign checkY     = w_y;
  assign pixelData  = r_pixelData;
  assign pixelValid = r_pixelValid;
  assign frameStart = r_frameStart;
  assign lineEnd    = r_lineEnd;
  assign physicsClk = r_physicsClk;

endmodule

// File: tb/tb_ball_frame_scanner.sv
// Bench for ball_frame_scanner: full 320x240 instance plus a small 8x4 FRAME_DIV=2 instance,
// both compared cycle by cycle with an index-based stream model.
module tb_ball_frame_scanner;
  import lcd_pkg::*;

  localparam int H = 320, V = 240, FRAME = H * V;
  localparam int SH = 8, SV = 4, SDIV = 2, SFRAME = SH * SV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, enable, isSet, pixelReady;
  logic [8:0] checkX;
  logic [7:0] checkY;
  rgb565_t    pixelData;
  logic       pixelValid, frameStart, lineEnd, physicsClk;

  logic       s_rstN, s_enable, s_isSet, s_ready;
  logic [8:0] s_checkX;
  logic [7:0] s_checkY;
  rgb565_t    s_data;
  logic       s_valid, s_fs, s_le, s_phys;

  int          n_checks, n_fail;
  logic        ball_mode;
  logic [63:0] mask;

  int   m_next, m_idx, s_next, s_idx;
  logic m_valid, m_phys, s_valid_m, s_phys_m;

  ball_frame_scanner #(.H_RES(H), .V_RES(V), .FRAME_DIV(1)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .checkX(checkX), .checkY(checkY),
    .isSet(isSet), .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .frameStart(frameStart), .lineEnd(lineEnd), .physicsClk(physicsClk)
  );

  ball_frame_scanner #(.H_RES(SH), .V_RES(SV), .FRAME_DIV(SDIV)) dut_s (
    .clk(clk), .rstN(s_rstN), .enable(s_enable), .checkX(s_checkX), .checkY(s_checkY),
    .isSet(s_isSet), .pixelData(s_data), .pixelValid(s_valid), .pixelReady(s_ready),
    .frameStart(s_fs), .lineEnd(s_le), .physicsClk(s_phys)
  );

  function automatic logic pat(int x, int y, logic [63:0] m);
    return m[(x + 7 * y) % 61];
  endfunction

  // Renderer stand-ins: a single lit pixel at (5,3), or a random pattern.
  always_comb isSet = ball_mode ? (checkX == 9'd5 && checkY == 8'd3)
                                : pat(int'(checkX), int'(checkY), mask);
  always_comb s_isSet = pat(int'(s_checkX), int'(s_checkY), mask);

  function automatic rgb565_t exp_main(int idx);
    int x, y;
    x = idx % H;
    y = (idx / H) % V;
    if (ball_mode) return (x == 5 && y == 3) ? 16'hFFFF : 16'h001F;
    return pat(x, y, mask) ? 16'hFFFF : 16'h001F;
  endfunction

  function automatic rgb565_t exp_small(int idx);
    return pat(idx % SH, (idx / SH) % SV, mask) ? 16'hFFFF : 16'h001F;
  endfunction

  task automatic tick_main();
    if (enable && (!m_valid || pixelReady)) begin
      m_valid = 1'b1;
      m_idx   = m_next;
      m_phys  = (m_next % FRAME == FRAME - 1);
      m_next++;
    end else begin
      if (pixelReady) m_valid = 1'b0;
      m_phys = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_small();
    if (s_enable && (!s_valid_m || s_ready)) begin
      s_valid_m = 1'b1;
      s_idx     = s_next;
      s_phys_m  = (s_next % SFRAME == SFRAME - 1) && (((s_next / SFRAME) + 1) % SDIV == 0);
      s_next++;
    end else begin
      if (s_ready) s_valid_m = 1'b0;
      s_phys_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_main();
    rstN = 1'b0;
    m_next = 0; m_idx = 0; m_valid = 1'b0; m_phys = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; enable = 1'b0; pixelReady = 1'b1; ball_mode = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({checkX, checkY} !== 17'd0) begin
      n_fail++; $display("FAIL reset_coords: got x=%0d y=%0d, want 0 0", checkX, checkY);
    end
    n_checks++;
    if (pixelValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, want 0", pixelValid);
    end
    n_checks++;
    if (pixelData !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h, want 0000", pixelData);
    end
    n_checks++;
    if ({frameStart, lineEnd, physicsClk} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got fs/le/phys=%b%b%b, want 000", frameStart, lineEnd, physicsClk);
    end
    m_next = 0; m_idx = 0; m_valid = 1'b0; m_phys = 1'b0;
    rstN = 1'b1;
  endtask

  task automatic test_full_frame();
    int acc, le_cnt, ph_cnt, span;
    int fs_pos[$];
    rgb565_t got965;
    acc = 0; le_cnt = 0; ph_cnt = 0; got965 = '0;
    ball_mode = 1'b1; pixelReady = 1'b1; enable = 1'b1;
    tick_main();
    n_checks++;
    if ({pixelValid, frameStart, pixelData} !== {1'b1, 1'b1, 16'h001F}) begin
      n_fail++; $display("FAIL first_pixel: got valid=%b fs=%b data=%h, want 1 1 001f", pixelValid, frameStart, pixelData);
    end
    for (int c = 0; c < FRAME + 5 && n_fail < 40; c++) begin
      n_checks++;
      if ({pixelValid, physicsClk, checkX, checkY} !== {m_valid, m_phys, 9'(m_next % H), 8'((m_next / H) % V)}) begin
        n_fail++;
        $display("FAIL frame_ctrl c=%0d: got v=%b p=%b x=%0d y=%0d, want v=%b p=%b x=%0d y=%0d", c, pixelValid, physicsClk,
                 checkX, checkY, m_valid, m_phys, m_next % H, (m_next / H) % V);
      end
      if (m_valid) begin
        n_checks++;
        if ({pixelData, frameStart, lineEnd} !== {exp_main(m_idx), m_idx % FRAME == 0, m_idx % H == H - 1}) begin
          n_fail++;
          $display("FAIL frame_pixel idx=%0d: got %h fs=%b le=%b, want %h fs=%b le=%b", m_idx, pixelData, frameStart,
                   lineEnd, exp_main(m_idx), m_idx % FRAME == 0, m_idx % H == H - 1);
        end
      end
      if (pixelValid && pixelReady) begin
        if (frameStart) fs_pos.push_back(acc);
        if (lineEnd && acc < FRAME) le_cnt++;
        if (acc == 965) got965 = pixelData;
        acc++;
      end
      if (physicsClk) ph_cnt++;
      tick_main();
    end
    span = (fs_pos.size() >= 2) ? fs_pos[1] - fs_pos[0] : -1;
    n_checks++;
    if (span != FRAME) begin
      n_fail++; $display("FAIL frame_length: got %0d pixels between frameStarts, want %0d", span, FRAME);
    end
    n_checks++;
    if (le_cnt != V) begin
      n_fail++; $display("FAIL line_end_count: got %0d, want %0d", le_cnt, V);
    end
    n_checks++;
    if (got965 !== 16'hFFFF) begin
      n_fail++; $display("FAIL ball_pixel_965: got %h, want ffff", got965);
    end
    n_checks++;
    if (ph_cnt != 1) begin
      n_fail++; $display("FAIL physics_pulses: got %0d, want 1", ph_cnt);
    end
    n_checks++;
    if (acc != FRAME + 5) begin
      n_fail++; $display("FAIL throughput: got %0d accepted, want %0d", acc, FRAME + 5);
    end
  endtask

  task automatic test_stall();
    logic [17:0] snap;
    enable = 1'b0; ball_mode = 1'b0; mask = {$urandom, $urandom}; pixelReady = 1'b1;
    reset_main();
    enable = 1'b1;
    for (int k = 0; k < 50 && !(m_valid && m_idx == 10); k++) tick_main();
    snap = {pixelData, frameStart, lineEnd};
    n_checks++;
    if (!pixelValid || snap !== {exp_main(10), 2'b00}) begin
      n_fail++; $display("FAIL stall_pix10: got v=%b %h, want v=1 %h", pixelValid, snap, {exp_main(10), 2'b00});
    end
    pixelReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick_main();
      n_checks++;
      if ({pixelValid, pixelData, frameStart, lineEnd, checkX} !== {1'b1, snap, 9'd11}) begin
        n_fail++; $display("FAIL stall_hold k=%0d: got v=%b %h x=%0d, want v=1 %h x=11", k, pixelValid,
                           {pixelData, frameStart, lineEnd}, checkX, snap);
      end
    end
    pixelReady = 1'b1;
    tick_main();
    n_checks++;
    if ({pixelValid, pixelData, checkX} !== {1'b1, exp_main(11), 9'd12}) begin
      n_fail++; $display("FAIL stall_next: got v=%b %h x=%0d, want v=1 %h x=12", pixelValid, pixelData, checkX, exp_main(11));
    end
  endtask

  task automatic test_reset_mid();
    int ph_cnt;
    ph_cnt = 0;
    enable = 1'b0; ball_mode = 1'b0; mask = {$urandom, $urandom}; pixelReady = 1'b1;
    reset_main();
    enable = 1'b1;
    for (int k = 0; k < 600 && !(m_valid && m_idx == 500); k++) tick_main();
    rstN = 1'b0;
    #1;
    n_checks++;
    if ({pixelValid, checkX, checkY} !== 18'd0) begin
      n_fail++; $display("FAIL async_drop: got v=%b x=%0d y=%0d, want 0 0 0", pixelValid, checkX, checkY);
    end
    m_next = 0; m_idx = 0; m_valid = 1'b0; m_phys = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    tick_main();
    n_checks++;
    if ({pixelValid, frameStart, pixelData} !== {1'b1, 1'b1, exp_main(0)}) begin
      n_fail++; $display("FAIL restart_first: got v=%b fs=%b %h, want 1 1 %h", pixelValid, frameStart, pixelData, exp_main(0));
    end
    for (int k = 0; k < 20; k++) begin
      if (physicsClk) ph_cnt++;
      tick_main();
    end
    n_checks++;
    if (ph_cnt != 0 || checkX != 9'd21) begin
      n_fail++; $display("FAIL restart_run: got phys=%0d x=%0d, want 0 21", ph_cnt, checkX);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; ball_mode = 1'b0; mask = {$urandom, $urandom}; pixelReady = 1'b1;
    reset_main();
    enable = 1'b1;
    for (int k = 0; k < 200 && !(m_valid && m_idx == 100); k++) tick_main();
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick_main();
      n_checks++;
      if ({pixelValid, checkX} !== {1'b0, 9'd101}) begin
        n_fail++; $display("FAIL enable_pause k=%0d: got v=%b x=%0d, want 0 101", k, pixelValid, checkX);
      end
    end
    enable = 1'b1;
    tick_main();
    n_checks++;
    if ({pixelValid, pixelData, frameStart, lineEnd, checkX} !== {1'b1, exp_main(101), 2'b00, 9'd102}) begin
      n_fail++; $display("FAIL enable_resume: got v=%b %h fs=%b le=%b x=%0d, want 1 %h 0 0 102", pixelValid, pixelData,
                         frameStart, lineEnd, checkX, exp_main(101));
    end
  endtask

  task automatic test_random_div2();
    int ph_cnt;
    ph_cnt = 0;
    enable = 1'b0;
    mask = {$urandom, $urandom};
    s_next = 0; s_idx = 0; s_valid_m = 1'b0; s_phys_m = 1'b0;
    s_enable = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    s_rstN = 1'b1;
    for (int c = 0; c < 800 && n_fail < 40; c++) begin
      s_enable = ($urandom_range(0, 3) != 0);
      s_ready  = ($urandom_range(0, 3) != 0);
      n_checks++;
      if ({s_valid, s_phys, s_checkX, s_checkY} !== {s_valid_m, s_phys_m, 9'(s_next % SH), 8'((s_next / SH) % SV)}) begin
        n_fail++; $display("FAIL rand_ctrl c=%0d: got v=%b p=%b x=%0d y=%0d, want v=%b p=%b x=%0d y=%0d", c, s_valid, s_phys,
                           s_checkX, s_checkY, s_valid_m, s_phys_m, s_next % SH, (s_next / SH) % SV);
      end
      if (s_valid_m) begin
        n_checks++;
        if ({s_data, s_fs, s_le} !== {exp_small(s_idx), s_idx % SFRAME == 0, s_idx % SH == SH - 1}) begin
          n_fail++; $display("FAIL rand_pixel idx=%0d: got %h fs=%b le=%b, want %h fs=%b le=%b", s_idx, s_data, s_fs, s_le,
                             exp_small(s_idx), s_idx % SFRAME == 0, s_idx % SH == SH - 1);
        end
      end
      if (s_phys) ph_cnt++;
      tick_small();
    end
    if (s_phys) ph_cnt++;
    n_checks++;
    if (ph_cnt != (s_next / SFRAME) / SDIV) begin
      n_fail++; $display("FAIL div2_pulses: got %0d, want %0d", ph_cnt, (s_next / SFRAME) / SDIV);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    mask = '0; ball_mode = 1'b1;
    s_rstN = 1'b0; s_enable = 1'b0; s_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_reset_mid();
    test_enable();
    test_random_div2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
